// File: rtl/demux_1_4_16_buf_pkg.sv
// rtl/demux_1_4_16_buf_pkg.sv - shared types and constants for the buffered 1:4 demux
package demux_pkg;

  typedef logic [1:0] sel_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } cnt_t;

  localparam int CHANNELS = 4;
  localparam int DEPTH    = 2;

  localparam sel_t SEL_A = 2'd0;
  localparam sel_t SEL_B = 2'd1;
  localparam sel_t SEL_C = 2'd2;
  localparam sel_t SEL_D = 2'd3;

  // One-hot strobe for the channel named by a select code
  function automatic logic [CHANNELS-1:0] sel_decode(input sel_t s);
    logic [CHANNELS-1:0] one;
    one = {{(CHANNELS-1){1'b0}}, 1'b1};
    return one << s;
  endfunction

endpackage

// File: rtl/demux_1_4_16_buf_if.sv
// rtl/demux_1_4_16_buf_if.sv - producer/consumer bus for the buffered 1:4 demux
interface demux_1_4_16_buf_if #(
  parameter int WIDTH = 16
);
  import demux_pkg::*;

  logic [WIDTH-1:0]    In_Data;
  sel_t                SelectBit;
  logic                In_Valid;
  logic                In_Ready;
  logic [WIDTH-1:0]    Out_A;
  logic [WIDTH-1:0]    Out_B;
  logic [WIDTH-1:0]    Out_C;
  logic [WIDTH-1:0]    Out_D;
  logic [CHANNELS-1:0] Out_Valid;
  logic [CHANNELS-1:0] Out_Ready;

  modport master (
    output In_Data, SelectBit, In_Valid, Out_Ready,
    input  In_Ready, Out_A, Out_B, Out_C, Out_D, Out_Valid
  );

  modport slave (
    input  In_Data, SelectBit, In_Valid, Out_Ready,
    output In_Ready, Out_A, Out_B, Out_C, Out_D, Out_Valid
  );

endinterface

// File: rtl/chan_fifo_2x16.sv
// rtl/chan_fifo_2x16.sv - two-entry per-channel FIFO with EMPTY/ONE/FULL count FSM
module chan_fifo_2x16
  import demux_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Push,
  input  logic [WIDTH-1:0] Push_Data,
  input  logic             Pop,
  output logic [WIDTH-1:0] Head,
  output logic             Valid,
  output logic             Full
);

  cnt_t             state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             do_push;
  logic             do_pop;

  // Pop on an empty channel and push into a full one are both no-ops
  assign do_push = Push && (state_q != FULL);
  assign do_pop  = Pop  && (state_q != EMPTY);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (do_push) begin
          state_d = ONE;
          head_d  = Push_Data;
        end
      end
      ONE: begin
        case ({do_push, do_pop})
          2'b10: begin
            state_d = FULL;
            tail_d  = Push_Data;
          end
          2'b01: state_d = EMPTY;
          // Head leaves while the new word arrives: it becomes the head directly
          2'b11: head_d = Push_Data;
          default: ;
        endcase
      end
      FULL: begin
        if (do_pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign Head  = head_q;
  assign Valid = (state_q != EMPTY);
  assign Full  = (state_q == FULL);

endmodule

// File: rtl/demux_1_4_16_buf.sv
// rtl/demux_1_4_16_buf.sv - buffered 1:4 demux routing words by select into four 2-deep channels
module demux_1_4_16_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  demux_1_4_16_buf_if.slave bus
);

  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] valid;
  logic [WIDTH-1:0]    head [CHANNELS];

  // Readiness reflects only the selected channel's occupancy, never its consumer
  assign bus.In_Ready = !full[bus.SelectBit];
  assign push         = (bus.In_Valid && bus.In_Ready) ? sel_decode(bus.SelectBit) : '0;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    chan_fifo_2x16 #(
      .WIDTH(WIDTH)
    ) u_chan (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .Push      (push[i]),
      .Push_Data (bus.In_Data),
      .Pop       (bus.Out_Ready[i]),
      .Head      (head[i]),
      .Valid     (valid[i]),
      .Full      (full[i])
    );
  end

  assign bus.Out_Valid = valid;
  assign bus.Out_A     = head[SEL_A];
  assign bus.Out_B     = head[SEL_B];
  assign bus.Out_C     = head[SEL_C];
  assign bus.Out_D     = head[SEL_D];

endmodule

// File: tb/tb_demux_1_4_16_buf.sv
// tb/tb_demux_1_4_16_buf.sv - randomized scoreboard bench for the buffered 1:4 demux
module tb_demux_1_4_16_buf;
  import demux_pkg::*;

  typedef logic [15:0] word_q_t[$];

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;
  int   model_pushes = 0;
  int   dut_pops = 0;
  bit   model_acc;
  sel_t model_sel;
  bit   rnd_acc;
  word_q_t mq [4];

  demux_1_4_16_buf_if #(.WIDTH(16)) bus ();

  demux_1_4_16_buf #(.WIDTH(16)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] out_of(input int i);
    case (i)
      0:       return bus.Out_A;
      1:       return bus.Out_B;
      2:       return bus.Out_C;
      default: return bus.Out_D;
    endcase
  endfunction

  // Reference: each channel is a queue of at most two words; pops before pushes
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
    end else begin
      model_sel = bus.SelectBit;
      model_acc = bus.In_Valid && (mq[model_sel].size() < 2);
      for (int i = 0; i < 4; i++)
        if (bus.Out_Ready[i] && mq[i].size() > 0) void'(mq[i].pop_front());
      if (model_acc) begin
        mq[model_sel].push_back(bus.In_Data);
        model_pushes++;
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en && Reset_n) begin
      check("in_ready", 32'(bus.In_Ready), 32'(mq[bus.SelectBit].size() < 2));
      for (int i = 0; i < 4; i++) begin
        check($sformatf("out_valid[%0d]", i), 32'(bus.Out_Valid[i]), 32'(mq[i].size() > 0));
        if (mq[i].size() > 0)
          check($sformatf("out_data[%0d]", i), 32'(out_of(i)), 32'(mq[i][0]));
        if (bus.Out_Valid[i] && bus.Out_Ready[i]) dut_pops++;
      end
    end
  end

  task automatic drive(input bit v, input sel_t s, input logic [15:0] d, input logic [3:0] ordy);
    bus.In_Valid  = v;
    bus.SelectBit = s;
    bus.In_Data   = d;
    bus.Out_Ready = ordy;
    @(posedge Clk);
    #1;
    bus.In_Valid  = 1'b0;
    bus.Out_Ready = 4'b0000;
  endtask

  initial begin
    bus.In_Valid  = 1'b0;
    bus.In_Data   = 16'h0;
    bus.SelectBit = SEL_A;
    bus.Out_Ready = 4'b0000;
    #12;
    check("reset_out_valid", 32'(bus.Out_Valid), 32'h0);
    check("reset_out_a", 32'(bus.Out_A), 32'h0);
    check("reset_out_b", 32'(bus.Out_B), 32'h0);
    check("reset_out_c", 32'(bus.Out_C), 32'h0);
    check("reset_out_d", 32'(bus.Out_D), 32'h0);
    for (int s = 0; s < 4; s++) begin
      bus.SelectBit = 2'(s);
      #1;
      check($sformatf("reset_in_ready_sel%0d", s), 32'(bus.In_Ready), 32'h1);
    end
    bus.SelectBit = SEL_A;
    Reset_n = 1'b1;
    chk_en  = 1'b1;

    drive(1'b1, SEL_C, 16'h1234, 4'b0000);
    check("push_c_valid", 32'(bus.Out_Valid), 32'h4);
    check("push_c_data", 32'(bus.Out_C), 32'h1234);
    drive(1'b0, SEL_A, 16'h0, 4'b0100);
    check("pop_c_valid", 32'(bus.Out_Valid), 32'h0);

    drive(1'b1, SEL_B, 16'hAAAA, 4'b0000);
    drive(1'b1, SEL_B, 16'hBBBB, 4'b0000);
    bus.SelectBit = SEL_B;
    #1;
    check("b_full_in_ready", 32'(bus.In_Ready), 32'h0);
    bus.SelectBit = SEL_A;
    #1;
    check("a_in_ready", 32'(bus.In_Ready), 32'h1);
    drive(1'b1, SEL_A, 16'hCCCC, 4'b0000);
    check("fill_valid", 32'(bus.Out_Valid), 32'h3);
    check("fill_out_a", 32'(bus.Out_A), 32'hCCCC);
    check("b_head_first", 32'(bus.Out_B), 32'hAAAA);
    drive(1'b0, SEL_A, 16'h0, 4'b0010);
    check("b_head_second", 32'(bus.Out_B), 32'hBBBB);
    drive(1'b0, SEL_A, 16'h0, 4'b0011);
    check("ab_drained", 32'(bus.Out_Valid), 32'h0);

    drive(1'b1, SEL_D, 16'h0001, 4'b0000);
    check("d_one_head", 32'(bus.Out_D), 32'h0001);
    drive(1'b1, SEL_D, 16'h0002, 4'b1000);
    check("d_pushpop_valid", 32'(bus.Out_Valid), 32'h8);
    check("d_pushpop_head", 32'(bus.Out_D), 32'h0002);
    drive(1'b0, SEL_A, 16'h0, 4'b1000);

    rnd_acc = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if (!bus.In_Valid || rnd_acc) begin
        bus.In_Valid  = ($urandom_range(3) != 0);
        bus.SelectBit = 2'($urandom);
        bus.In_Data   = 16'($urandom);
      end
      bus.Out_Ready = 4'($urandom);
      #1;
      rnd_acc = bus.In_Valid && bus.In_Ready;
      @(posedge Clk);
      #1;
    end
    bus.In_Valid  = 1'b0;
    bus.Out_Ready = 4'b1111;
    repeat (3) @(posedge Clk);
    #1;
    bus.Out_Ready = 4'b0000;
    check("drain_valid", 32'(bus.Out_Valid), 32'h0);
    check("no_loss_dup", 32'(dut_pops), 32'(model_pushes));

    drive(1'b1, SEL_A, 16'hA001, 4'b0000);
    drive(1'b1, SEL_A, 16'hA002, 4'b0000);
    drive(1'b1, SEL_C, 16'hC001, 4'b0000);
    check("pre_reset_valid", 32'(bus.Out_Valid), 32'h5);
    #3;
    Reset_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(bus.Out_Valid), 32'h0);
    check("async_reset_out_a", 32'(bus.Out_A), 32'h0);
    check("async_reset_out_c", 32'(bus.Out_C), 32'h0);
    bus.SelectBit = SEL_A;
    #1;
    check("async_reset_in_ready", 32'(bus.In_Ready), 32'h1);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    drive(1'b1, SEL_B, 16'h5555, 4'b0000);
    check("post_reset_valid", 32'(bus.Out_Valid), 32'h2);
    check("post_reset_out_b", 32'(bus.Out_B), 32'h5555);
    drive(1'b0, SEL_A, 16'h0, 4'b0010);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
